// File: rtl/rd_req_arbiter.sv
// Round-robin read-request arbiter with per-requester in-flight accounting,
// response routing by tag, and an enable-controlled drain sequence.
module rd_req_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 42,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*2-1:0]          req_len,
  output logic [NUM_REQ-1:0]            req_grant,
  input  logic                          c0_almfull,
  output logic                          rd_valid,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic [1:0]                    rd_len,
  output logic [15:0]                   rd_tag,
  input  logic                          rsp_valid,
  input  logic [15:0]                   rsp_tag,
  input  logic [1:0]                    rsp_cl_num,
  output logic [NUM_REQ-1:0]            rsp_route,
  output logic                          busy,
  output logic                          drained,
  output logic                          err
);

  // state | meaning
  // IDLE  | not arbitrating, nothing expected in flight
  // RUN   | arbitrating eligible requesters
  // DRAIN | no new grants, waiting for outstanding reads to return
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state;
  logic [1:0]         ptr;
  logic [3:0]         cnt     [NUM_REQ];
  logic [3:0]         cnt_nxt [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] len_bad;
  logic [NUM_REQ-1:0] rsp_hit;
  logic [NUM_REQ-1:0] dec;
  logic [NUM_REQ-1:0] dec_err;
  logic               grant_any;
  logic               found;
  logic [1:0]         winner;
  logic               rsp_id_ok;
  logic               rsp_last;
  logic               all_zero_nxt;
  logic               any_cnt;
  int                 idx;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      len_bad[i]  = req_valid[i] && (req_len[2*i +: 2] == 2'd2);
      eligible[i] = (state == RUN) && req_valid[i] && !len_bad[i] &&
                    (cnt[i] < 4'(MAX_OUTSTANDING));
    end
  end

  // First eligible requester at or after ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = 2'd0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = 2'(idx);
      end
    end
    grant_any = found && !c0_almfull && !reset;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_grant[i] = grant_any && (winner == 2'(i));
    end
  end

  always_comb begin
    rsp_id_ok    = rsp_valid && (int'(rsp_tag[1:0]) < NUM_REQ);
    rsp_last     = (rsp_cl_num == rsp_tag[3:2]);
    all_zero_nxt = 1'b1;
    any_cnt      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_hit[i] = rsp_id_ok && (rsp_tag[1:0] == 2'(i));
      dec[i]     = rsp_hit[i] && rsp_last;
      dec_err[i] = dec[i] && !req_grant[i] && (cnt[i] == 4'd0);
      cnt_nxt[i] = cnt[i];
      if (req_grant[i] && !dec[i]) begin
        cnt_nxt[i] = cnt[i] + 4'd1;
      end else if (dec[i] && !req_grant[i] && (cnt[i] != 4'd0)) begin
        cnt_nxt[i] = cnt[i] - 4'd1;
      end
      if (cnt_nxt[i] != 4'd0) all_zero_nxt = 1'b0;
      if (cnt[i] != 4'd0)     any_cnt      = 1'b1;
    end
    busy = any_cnt && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
      rd_len    <= 2'd0;
      rd_tag    <= 16'd0;
      rsp_route <= '0;
      drained   <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= 4'd0;
    end else begin
      drained <= 1'b0;
      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (!enable) state <= DRAIN;
        DRAIN: begin
          // Uses post-update counters so drained lands the cycle after the final beat.
          if (enable) begin
            state <= RUN;
          end else if (all_zero_nxt) begin
            state   <= IDLE;
            drained <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      rd_valid <= grant_any;
      if (grant_any) begin
        rd_addr <= req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
        rd_len  <= req_len[winner*2 +: 2];
        rd_tag  <= {12'd0, req_len[winner*2 +: 2], winner};
        ptr     <= 2'((int'(winner) + 1) % NUM_REQ);
      end

      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= cnt_nxt[i];
      rsp_route <= rsp_hit;

      if ((|len_bad) || (|dec_err) || (rsp_valid && !rsp_id_ok)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rd_req_arbiter.sv
// Directed bench for rd_req_arbiter: an integer-level reference model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_rd_req_arbiter;

  localparam int N   = 4;
  localparam int AW  = 42;
  localparam int MAX = 8;

  logic          clk = 1'b0;
  logic          reset, enable, c0_almfull;
  logic [N-1:0]  req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*2-1:0]  req_len;
  logic [N-1:0]  req_grant;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic [1:0]    rd_len;
  logic [15:0]   rd_tag;
  logic          rsp_valid;
  logic [15:0]   rsp_tag;
  logic [1:0]    rsp_cl_num;
  logic [N-1:0]  rsp_route;
  logic          busy, drained, err;

  logic [AW-1:0] a [N];
  logic [1:0]    l [N];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_len[i*2 +: 2]    = l[i];
    end
  end

  rd_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req_valid(req_valid),
    .req_addr(req_addr), .req_len(req_len), .req_grant(req_grant),
    .c0_almfull(c0_almfull), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_len(rd_len), .rd_tag(rd_tag), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
    .rsp_cl_num(rsp_cl_num), .rsp_route(rsp_route), .busy(busy),
    .drained(drained), .err(err)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: 0=idle 1=run 2=drain
  int            m_state, m_ptr, m_g;
  int            m_cnt [N];
  bit            m_err, m_drained, m_rd_valid, started;
  logic [AW-1:0] m_rd_addr;
  logic [1:0]    m_rd_len;
  logic [15:0]   m_rd_tag;
  logic [N-1:0]  m_route;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_err = 0; m_drained = 0; m_rd_valid = 0;
    m_rd_addr = '0; m_rd_len = 0; m_rd_tag = 0; m_route = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic settle_check();
    logic [N-1:0] g_exp;
    bit any;
    #1;
    m_g = -1;
    if (!reset && m_state == 1 && !c0_almfull) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (m_g < 0 && req_valid[i] && l[i] != 2 && m_cnt[i] < MAX) m_g = i;
      end
    end
    g_exp = '0;
    if (m_g >= 0) g_exp[m_g] = 1'b1;
    any = 0;
    for (int i = 0; i < N; i++) if (m_cnt[i] > 0) any = 1;
    if (started) begin
      chk("req_grant", 64'(req_grant), 64'(g_exp));
      chk("busy", 64'(busy), 64'(any && !reset));
      chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
      chk("rd_addr", 64'(rd_addr), 64'(m_rd_addr));
      chk("rd_len", 64'(rd_len), 64'(m_rd_len));
      chk("rd_tag", 64'(rd_tag), 64'(m_rd_tag));
      chk("rsp_route", 64'(rsp_route), 64'(m_route));
      chk("drained", 64'(drained), 64'(m_drained));
      chk("err", 64'(err), 64'(m_err));
    end
  endtask

  task automatic advance();
    int id, sum;
    bit last;
    if (reset) begin
      model_reset();
    end else begin
      m_rd_valid = (m_g >= 0);
      if (m_g >= 0) begin
        m_rd_addr = a[m_g];
        m_rd_len  = l[m_g];
        m_rd_tag  = {12'd0, l[m_g], 2'(m_g)};
        m_ptr     = (m_g + 1) % N;
      end
      for (int i = 0; i < N; i++) if (req_valid[i] && l[i] == 2) m_err = 1;
      id = int'(rsp_tag[1:0]);
      last = rsp_valid && (rsp_cl_num == rsp_tag[3:2]);
      m_route = '0;
      if (rsp_valid && id >= N) m_err = 1;
      if (rsp_valid && id < N) m_route[id] = 1'b1;
      for (int i = 0; i < N; i++) begin
        int up, dn;
        up = (m_g == i) ? 1 : 0;
        dn = (last && id == i) ? 1 : 0;
        if (dn == 1 && up == 0 && m_cnt[i] == 0) m_err = 1;
        else m_cnt[i] = m_cnt[i] + up - dn;
      end
      sum = 0;
      for (int i = 0; i < N; i++) sum += m_cnt[i];
      m_drained = 0;
      if (m_state == 0 && enable) m_state = 1;
      else if (m_state == 1 && !enable) m_state = 2;
      else if (m_state == 2) begin
        if (enable) m_state = 1;
        else if (sum == 0) begin m_state = 0; m_drained = 1; end
      end
    end
    started = 1;
    @(negedge clk);
  endtask

  task automatic cyc();
    settle_check();
    advance();
  endtask

  task automatic beat(input logic [15:0] tag, input logic [1:0] cl);
    rsp_valid = 1'b1; rsp_tag = tag; rsp_cl_num = cl;
    cyc();
    rsp_valid = 1'b0; rsp_tag = 16'd0; rsp_cl_num = 2'd0;
  endtask

  logic [3:0] nib [5];
  int ng;

  initial begin
    reset = 1'b1; enable = 1'b0; c0_almfull = 1'b0; req_valid = '0;
    rsp_valid = 1'b0; rsp_tag = 16'd0; rsp_cl_num = 2'd0; started = 0;
    for (int i = 0; i < N; i++) begin a[i] = '0; l[i] = 2'd0; end
    model_reset();
    nib[0] = 4'hC; nib[1] = 4'hD; nib[2] = 4'hE; nib[3] = 4'hF; nib[4] = 4'hC;
    @(negedge clk);
    advance();
    cyc();
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    // All four requesting, len=3: round robin 0,1,2,3,0
    enable = 1'b1; req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      a[i] = AW'(64'h1000_0000 + 64'(i) * 64'h40); l[i] = 2'd3;
    end
    cyc();
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rr_rd_valid", 64'(rd_valid), 64'd1);
      chk("rr_tag_nibble", 64'(rd_tag[3:0]), 64'(nib[k]));
    end
    req_valid = '0;
    beat(16'h000C, 2'd0);
    chk("route_nonlast", 64'(rsp_route), 64'h1);
    beat(16'h000C, 2'd3);
    beat(16'h000C, 2'd3);
    beat(16'h000D, 2'd3);
    beat(16'h000E, 2'd3);
    beat(16'h000F, 2'd3);
    chk("rr_busy_cleared", 64'(busy), 64'd0);

    // Requester 1 alone up to the outstanding limit
    req_valid = 4'b0010; l[1] = 2'd1; a[1] = AW'(64'h2_0000_1000);
    ng = 0;
    for (int k = 0; k < 10; k++) begin
      settle_check();
      if (req_grant == 4'b0010) ng++;
      advance();
    end
    chk("limit_grant_count", 64'(ng), 64'd8);
    rsp_valid = 1'b1; rsp_tag = 16'h0005; rsp_cl_num = 2'd1;
    settle_check();
    chk("limit_blocked", 64'(req_grant), 64'd0);
    advance();
    rsp_valid = 1'b0; rsp_tag = 16'd0; rsp_cl_num = 2'd0;
    settle_check();
    chk("limit_ninth_grant", 64'(req_grant), 64'b0010);
    advance();
    req_valid = '0;
    for (int k = 0; k < 8; k++) beat(16'h0005, 2'd1);
    chk("limit_busy_cleared", 64'(busy), 64'd0);

    // Almost-full holds off grants; pointer sits at 2
    c0_almfull = 1'b1; req_valid = 4'b0101; l[0] = 2'd0; l[2] = 2'd0;
    for (int k = 0; k < 5; k++) begin
      settle_check();
      chk("almfull_no_grant", 64'(req_grant), 64'd0);
      advance();
      chk("almfull_no_rd", 64'(rd_valid), 64'd0);
    end
    c0_almfull = 1'b0;
    settle_check();
    chk("almfull_fall_grant", 64'(req_grant), 64'b0100);
    advance();
    req_valid = '0;
    chk("almfull_rd_tag", 64'(rd_tag), 64'h0002);
    beat(16'h0002, 2'd0);

    // Two outstanding, then drain
    req_valid = 4'b0011; l[0] = 2'd0; l[1] = 2'd0;
    cyc();
    cyc();
    req_valid = '0; enable = 1'b0;
    cyc();
    chk("drain_busy", 64'(busy), 64'd1);
    req_valid = 4'b1111;
    settle_check();
    chk("drain_no_grant", 64'(req_grant), 64'd0);
    advance();
    req_valid = '0;
    beat(16'h0000, 2'd0);
    chk("drain_not_yet", 64'(drained), 64'd0);
    beat(16'h0001, 2'd0);
    chk("drained_pulse", 64'(drained), 64'd1);
    cyc();
    chk("drained_one_cycle", 64'(drained), 64'd0);

    // Grant and last beat to requester 2 in the same cycle at cnt=3
    enable = 1'b1; req_valid = 4'b0100; l[2] = 2'd0; a[2] = AW'(64'h3_0000_2000);
    cyc();
    for (int k = 0; k < 3; k++) cyc();
    rsp_valid = 1'b1; rsp_tag = 16'h0002; rsp_cl_num = 2'd0;
    cyc();
    rsp_valid = 1'b0; rsp_tag = 16'd0; req_valid = '0;
    chk("same_cycle_route", 64'(rsp_route), 64'b0100);
    beat(16'h0002, 2'd0);
    beat(16'h0002, 2'd0);
    chk("same_cycle_busy", 64'(busy), 64'd1);
    beat(16'h0002, 2'd0);
    chk("same_cycle_cnt3", 64'(busy), 64'd0);

    // Underflow beat sets sticky err
    beat(16'h0000, 2'd0);
    chk("underflow_err", 64'(err), 64'd1);
    cyc(); cyc(); cyc();
    chk("err_sticky", 64'(err), 64'd1);
    chk("no_underflow", 64'(busy), 64'd0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("err_cleared", 64'(err), 64'd0);

    // Illegal length is never granted
    enable = 1'b1; req_valid = 4'b0001; l[0] = 2'd2;
    cyc();
    settle_check();
    chk("len2_no_grant", 64'(req_grant), 64'd0);
    advance();
    chk("len2_err", 64'(err), 64'd1);
    req_valid = '0; l[0] = 2'd0;

    // Reset mid-flight forgets accounting
    reset = 1'b1; cyc(); reset = 1'b0;
    req_valid = 4'b0001;
    cyc(); cyc();
    req_valid = '0;
    cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("midreset_busy", 64'(busy), 64'd0);
    beat(16'h0000, 2'd0);
    chk("midreset_err", 64'(err), 64'd1);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
